// File: rtl/aes_pkg.sv
// Shared AES types, arbiter FSM encoding and the byte-level S-box function.
// The S-box is computed as a GF(2^8) inverse followed by the affine transform, not read from a table.
package aes_pkg;

    typedef logic [127:0] aes_128;
    typedef logic [31:0]  aes_32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SUB_D,
        ST_SUB_K,
        ST_DONE_D,
        ST_DONE_K
    } arb_state_e;

    typedef enum logic {
        SEL_DATA = 1'b0,
        SEL_KEY  = 1'b1
    } req_sel_e;

    localparam bit KEY_PRIO_DEFAULT = 1'b0;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // Inverse as a^254; 254 has bits 1..7 set. Zero maps to zero, as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = a;
        for (int i = 0; i < 8; i++) begin
            if (i != 0) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/aes_sbox_arb_if.sv
// Requester-side bus of the shared S-box arbiter: data SubBytes and key SubWord channels.
interface aes_sbox_arb_if;

    logic           d_req;
    aes_pkg::aes_128 d_in;
    logic           d_gnt;
    logic           d_done;
    aes_pkg::aes_128 d_out;
    logic           k_req;
    aes_pkg::aes_32  k_in;
    logic           k_gnt;
    logic           k_done;
    aes_pkg::aes_32  k_out;
    logic           busy;

    modport master (
        output d_req, d_in, k_req, k_in,
        input  d_gnt, d_done, d_out, k_gnt, k_done, k_out, busy
    );

    modport slave (
        input  d_req, d_in, k_req, k_in,
        output d_gnt, d_done, d_out, k_gnt, k_done, k_out, busy
    );

endinterface

// File: rtl/aes_sbox_arb_sbox.sv
// Sixteen-lane combinational S-box; in key mode the low four lanes take the key word instead.
module aes_sbox
    import aes_pkg::*;
(
    input  aes_128 in_i,
    input  aes_32  key_in_i,
    input  logic   key_gen_i,
    output aes_128 out_o,
    output aes_32  key_out_o
);

    aes_128 lane_in;

    always_comb begin
        lane_in = in_i;
        if (key_gen_i) lane_in[31:0] = key_in_i;
    end

    for (genvar b = 0; b < 16; b++) begin : g_lane
        assign out_o[8*b +: 8] = sbox_byte(lane_in[8*b +: 8]);
    end

    assign key_out_o = out_o[31:0];

endmodule

// File: rtl/aes_sbox_arb.sv
// Time-multiplexes one S-box between the data-path and key-expansion requesters.
// Every output is registered; a result and its done pulse follow the grant pulse by two cycles.
module aes_sbox_arb
    import aes_pkg::*;
#(
    parameter bit KEY_PRIO = KEY_PRIO_DEFAULT
) (
    input  logic           clk,
    input  logic           rst,
    aes_sbox_arb_if.slave  bus
);

    arb_state_e state_q, state_d;
    req_sel_e   last_q, last_d;
    aes_128     d_op_q, d_out_q;
    aes_32      k_op_q, k_out_q;
    logic       d_gnt_q, k_gnt_q, d_done_q, k_done_q, busy_q;
    logic       grant_d, grant_k, done_d, done_k;

    aes_128     sbox_in, sbox_out;
    aes_32      sbox_key_in, sbox_key_out;
    logic       sbox_key_gen;

    aes_sbox u_sbox (
        .in_i      (sbox_in),
        .key_in_i  (sbox_key_in),
        .key_gen_i (sbox_key_gen),
        .out_o     (sbox_out),
        .key_out_o (sbox_key_out)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        state_d      = state_q;
        last_d       = last_q;
        grant_d      = 1'b0;
        grant_k      = 1'b0;
        done_d       = 1'b0;
        done_k       = 1'b0;
        sbox_in      = '0;
        sbox_key_in  = '0;
        sbox_key_gen = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.d_req && bus.k_req) begin
                    if (KEY_PRIO || last_q == SEL_DATA) grant_k = 1'b1;
                    else                                grant_d = 1'b1;
                end else if (bus.k_req) begin
                    grant_k = 1'b1;
                end else if (bus.d_req) begin
                    grant_d = 1'b1;
                end
                if (grant_k)      state_d = ST_SUB_K;
                else if (grant_d) state_d = ST_SUB_D;
            end
            ST_SUB_D: begin
                sbox_in = d_op_q;
                state_d = ST_DONE_D;
            end
            ST_SUB_K: begin
                sbox_key_gen = 1'b1;
                sbox_key_in  = k_op_q;
                state_d      = ST_DONE_K;
            end
            ST_DONE_D: begin
                done_d  = 1'b1;
                last_d  = SEL_DATA;
                state_d = ST_IDLE;
            end
            ST_DONE_K: begin
                done_k  = 1'b1;
                last_d  = SEL_KEY;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            last_q   <= SEL_DATA;
            d_op_q   <= '0;
            k_op_q   <= '0;
            d_out_q  <= '0;
            k_out_q  <= '0;
            d_gnt_q  <= 1'b0;
            k_gnt_q  <= 1'b0;
            d_done_q <= 1'b0;
            k_done_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            d_gnt_q  <= grant_d;
            k_gnt_q  <= grant_k;
            d_done_q <= done_d;
            k_done_q <= done_k;
            busy_q   <= (state_d != ST_IDLE);
            if (grant_d)              d_op_q  <= bus.d_in;
            if (grant_k)              k_op_q  <= bus.k_in;
            if (state_q == ST_SUB_D)  d_out_q <= sbox_out;
            if (state_q == ST_SUB_K)  k_out_q <= sbox_key_out;
        end
    end

    assign bus.d_gnt  = d_gnt_q;
    assign bus.k_gnt  = k_gnt_q;
    assign bus.d_done = d_done_q;
    assign bus.k_done = k_done_q;
    assign bus.d_out  = d_out_q;
    assign bus.k_out  = k_out_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_aes_sbox_arb.sv
// Directed bench for aes_sbox_arb: round-robin instance (dut0) and key-priority instance (dut1).
module tb_aes_sbox_arb;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    aes_sbox_arb_if bus0();
    aes_sbox_arb_if bus1();

    aes_sbox_arb #(.KEY_PRIO(1'b0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    aes_sbox_arb #(.KEY_PRIO(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    logic [1:0] exp_g;
    logic [1:0] exp_dn;

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        bus0.d_req = 1'b0; bus0.k_req = 1'b0; bus0.d_in = '0; bus0.k_in = '0;
        bus1.d_req = 1'b0; bus1.k_req = 1'b0; bus1.d_in = '0; bus1.k_in = '0;
        tick();
        tick();

        // Reset state
        check("rst d_gnt/k_gnt", {bus0.d_gnt, bus0.k_gnt, bus1.d_gnt, bus1.k_gnt}, 0);
        check("rst done", {bus0.d_done, bus0.k_done, bus1.d_done, bus1.k_done}, 0);
        check("rst busy", {bus0.busy, bus1.busy}, 0);
        check("rst d_out", bus0.d_out, 0);
        check("rst k_out", bus0.k_out, 0);
        rst = 1'b0;

        // Data op on zero state
        bus0.d_in  = '0;
        bus0.d_req = 1'b1;
        tick();
        check("d0 gnt N", {bus0.d_gnt, bus0.k_gnt, bus0.busy}, 3'b101);
        bus0.d_req = 1'b0;
        tick();
        check("d0 done N+1", bus0.d_done, 1'b0);
        tick();
        check("d0 done N+2", {bus0.d_done, bus0.k_done, bus0.busy}, 3'b100);
        check("d0 d_out", bus0.d_out, 128'h63636363_63636363_63636363_63636363);
        tick();
        check("d0 done drops", bus0.d_done, 1'b0);
        check("d0 d_out holds", bus0.d_out, 128'h63636363_63636363_63636363_63636363);

        // Key op 0x00010203
        bus0.k_in  = 32'h00010203;
        bus0.k_req = 1'b1;
        tick();
        check("k0 gnt N", {bus0.d_gnt, bus0.k_gnt}, 2'b01);
        bus0.k_req = 1'b0;
        tick();
        tick();
        check("k0 done N+2", {bus0.d_done, bus0.k_done}, 2'b01);
        check("k0 k_out", bus0.k_out, 32'h637C777B);
        check("k0 d_out unchanged", bus0.d_out, 128'h63636363_63636363_63636363_63636363);

        // Data op on bytes 00..0f; operand overwritten right after the grant
        bus0.d_in  = 128'h00010203_04050607_08090a0b_0c0d0e0f;
        bus0.d_req = 1'b1;
        tick();
        check("d1 gnt", bus0.d_gnt, 1'b1);
        bus0.d_req = 1'b0;
        bus0.d_in  = {128{1'b1}};
        tick();
        tick();
        check("d1 done", bus0.d_done, 1'b1);
        check("d1 d_out grant operand", bus0.d_out, 128'h637c777b_f26b6fc5_3001672b_fed7ab76);
        check("d1 k_out unchanged", bus0.k_out, 32'h637C777B);

        // Data op on all-FF
        bus0.d_req = 1'b1;
        tick();
        bus0.d_req = 1'b0;
        tick();
        tick();
        check("d2 d_out all-FF", bus0.d_out, 128'h16161616_16161616_16161616_16161616);

        // Round-robin tie for 12 cycles: K,D,K,D one every 3 cycles
        bus0.d_in  = '0;
        bus0.k_in  = 32'h00010203;
        bus0.d_req = 1'b1;
        bus0.k_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_g  = (i % 6 == 1) ? 2'b01 : (i % 6 == 4) ? 2'b10 : 2'b00;
            exp_dn = (i % 6 == 3) ? 2'b01 : (i % 6 == 0) ? 2'b10 : 2'b00;
            check($sformatf("rr gnt c%0d", i), {bus0.d_gnt, bus0.k_gnt}, exp_g);
            check($sformatf("rr done c%0d", i), {bus0.d_done, bus0.k_done}, exp_dn);
        end
        bus0.d_req = 1'b0;
        bus0.k_req = 1'b0;
        tick();

        // Key-priority tie for 12 cycles: only key is ever granted
        bus1.d_in  = '0;
        bus1.k_in  = 32'h00010203;
        bus1.d_req = 1'b1;
        bus1.k_req = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            exp_g  = (i % 3 == 1) ? 2'b01 : 2'b00;
            exp_dn = (i % 3 == 0) ? 2'b01 : 2'b00;
            check($sformatf("kp gnt c%0d", i), {bus1.d_gnt, bus1.k_gnt}, exp_g);
            check($sformatf("kp done c%0d", i), {bus1.d_done, bus1.k_done}, exp_dn);
        end
        bus1.d_req = 1'b0;
        bus1.k_req = 1'b0;
        tick();
        check("kp k_out", bus1.k_out, 32'h637C777B);
        check("kp d_out untouched", bus1.d_out, 128'h0);

        // Reset in SUB_K aborts the op; a fresh key request follows immediately
        bus0.k_in  = 32'hdeadbeef;
        bus0.k_req = 1'b1;
        tick();
        check("ab gnt", bus0.k_gnt, 1'b1);
        bus0.k_req = 1'b0;
        rst = 1'b1;
        tick();
        check("ab no done", {bus0.d_done, bus0.k_done}, 2'b00);
        check("ab k_out cleared", bus0.k_out, 32'h0);
        check("ab d_out cleared", bus0.d_out, 128'h0);
        check("ab busy", bus0.busy, 1'b0);
        rst = 1'b0;
        bus0.k_in  = 32'h53000102;
        bus0.k_req = 1'b1;
        tick();
        check("ab2 gnt first cycle", {bus0.d_gnt, bus0.k_gnt}, 2'b01);
        bus0.k_req = 1'b0;
        tick();
        check("ab2 no early done", bus0.k_done, 1'b0);
        tick();
        check("ab2 done", bus0.k_done, 1'b1);
        check("ab2 k_out", bus0.k_out, 32'hED637C77);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
